// File: rtl/max7219_sequencer.sv
// MAX7219 LED-matrix sequencer: sends the five-word init sequence, then
// refreshes eight rows per frame from an external row source, with an
// idle gap between frames and an intensity resend when intensity changes.
module max7219_sequencer #(
   parameter int CLK_DIV   = 4,
   parameter int FRAME_GAP = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [3:0] intensity,
   output logic       row_req,
   output logic [2:0] row_sel,
   input  logic [7:0] col,
   input  logic       col_valid,
   output logic       spi_din,
   output logic       spi_clk,
   output logic       spi_cs_n,
   output logic       busy,
   output logic       frame_done,
   output logic [2:0] state_dbg
);

   // Row handshake: row_req acts as "ready" and stays high with row_sel
   // stable until the source answers with col_valid=1 (the "valid");
   // col is captured on that cycle and row_req drops on the next one.
   // col_valid is ignored whenever row_req is low.

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_REQ_ROW = 3'd2,
      S_SHIFT   = 3'd3,
      S_LATCH   = 3'd4,
      S_GAP     = 3'd5
   } state_t;

   // Kind of the word in flight decides where LATCH goes next
   localparam logic [1:0] K_INIT = 2'd0;
   localparam logic [1:0] K_ROW  = 2'd1;
   localparam logic [1:0] K_INT  = 2'd2;

   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP - 1);

   state_t      state, nxt;
   logic [15:0] shreg;
   logic [7:0]  div_cnt;
   logic        phase;
   logic [3:0]  bit_cnt;
   logic [15:0] gap_cnt;
   logic [2:0]  init_idx;
   logic [1:0]  kind;
   logic [2:0]  row_q;
   logic [3:0]  last_int;
   logic        fd_q;

   logic        shifting, div_end, word_end;
   logic        load, init_inc, row_clr, row_inc, fd_set, gap_exit;
   logic [15:0] load_val;
   logic [1:0]  load_kind;

   function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
      logic [15:0] w;
      case (idx)
         3'd0:    w = 16'h0C01;
         3'd1:    w = 16'h0900;
         3'd2:    w = 16'h0B07;
         3'd3:    w = {12'h0A0, inten};
         default: w = 16'h0F00;
      endcase
      return w;
   endfunction

   assign shifting = (state == S_INIT) || (state == S_SHIFT);
   assign div_end  = (div_cnt == DIV_LAST);
   assign word_end = shifting && div_end && phase && (bit_cnt == 4'd15);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   // Next-state and word-load decisions
   always_comb begin
      nxt       = state;
      load      = 1'b0;
      load_val  = 16'h0000;
      load_kind = K_INIT;
      init_inc  = 1'b0;
      row_clr   = 1'b0;
      row_inc   = 1'b0;
      fd_set    = 1'b0;
      gap_exit  = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable) begin
               nxt      = S_INIT;
               load     = 1'b1;
               load_val = init_word(3'd0, intensity);
               row_clr  = 1'b1;
            end
         end
         S_INIT, S_SHIFT: begin
            if (word_end) nxt = S_LATCH;
         end
         S_REQ_ROW: begin
            if (!enable) nxt = S_IDLE;
            else if (col_valid) begin
               nxt       = S_SHIFT;
               load      = 1'b1;
               load_val  = {4'h0, {1'b0, row_q} + 4'd1, col};
               load_kind = K_ROW;
            end
         end
         S_LATCH: begin
            if (div_end) begin
               if (!enable) nxt = S_IDLE;
               else if (kind == K_INIT) begin
                  if (init_idx != 3'd4) begin
                     nxt      = S_INIT;
                     load     = 1'b1;
                     load_val = init_word(init_idx + 3'd1, intensity);
                     init_inc = 1'b1;
                  end else begin
                     nxt     = S_REQ_ROW;
                     row_clr = 1'b1;
                  end
               end else if (kind == K_INT) begin
                  nxt     = S_REQ_ROW;
                  row_clr = 1'b1;
               end else if (row_q != 3'd7) begin
                  nxt     = S_REQ_ROW;
                  row_inc = 1'b1;
               end else begin
                  fd_set = 1'b1;
                  if (FRAME_GAP == 0) gap_exit = 1'b1;
                  else                nxt = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (!enable) nxt = S_IDLE;
            else if (gap_cnt == GAP_LAST) gap_exit = 1'b1;
         end
         default: nxt = S_IDLE;
      endcase
      // Frame boundary: resend intensity only if it moved since last sent
      if (gap_exit) begin
         if (intensity != last_int) begin
            nxt       = S_SHIFT;
            load      = 1'b1;
            load_val  = {12'h0A0, intensity};
            load_kind = K_INT;
         end else begin
            nxt     = S_REQ_ROW;
            row_clr = 1'b1;
         end
      end
   end

   // Datapath: shifter, bit/divider timing, row and gap counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg    <= 16'h0000;
         div_cnt  <= 8'd0;
         phase    <= 1'b0;
         bit_cnt  <= 4'd0;
         gap_cnt  <= 16'd0;
         init_idx <= 3'd0;
         kind     <= K_INIT;
         row_q    <= 3'd0;
         last_int <= 4'd0;
         fd_q     <= 1'b0;
      end else begin
         fd_q <= fd_set;
         if (row_clr)      row_q <= 3'd0;
         else if (row_inc) row_q <= row_q + 3'd1;
         if (state == S_IDLE) init_idx <= 3'd0;
         else if (init_inc)   init_idx <= init_idx + 3'd1;
         if (load) kind <= load_kind;
         // Intensity words are the only ones with 0x0A0 in the top bits
         if (load && (load_val[15:4] == 12'h0A0)) last_int <= load_val[3:0];
         if (state == S_GAP) gap_cnt <= gap_cnt + 16'd1;
         else                gap_cnt <= 16'd0;
         if (load) begin
            shreg   <= load_val;
            div_cnt <= 8'd0;
            phase   <= 1'b0;
            bit_cnt <= 4'd0;
         end else if (shifting || (state == S_LATCH)) begin
            if (div_end) begin
               div_cnt <= 8'd0;
               if (shifting) begin
                  if (!phase) phase <= 1'b1;
                  else begin
                     phase   <= 1'b0;
                     shreg   <= {shreg[14:0], 1'b0};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
         end else begin
            div_cnt <= 8'd0;
         end
      end
   end

   // Outputs decoded from state and datapath
   always_comb begin
      row_req    = (state == S_REQ_ROW);
      busy       = (state != S_IDLE);
      spi_cs_n   = !shifting;
      spi_clk    = shifting && phase;
      spi_din    = shifting && shreg[15];
      row_sel    = row_q;
      frame_done = fd_q;
      state_dbg  = state;
   end

endmodule

// File: tb/tb_max7219_sequencer.sv
// Bench for max7219_sequencer: SPI words are decoded by a monitor and
// checked against an expected-word queue filled by the stimulus.
module tb_max7219_sequencer;

   localparam int CLK_DIV   = 1;
   localparam int FRAME_GAP = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] intensity = 4'h5;
   logic       row_req;
   logic [2:0] row_sel;
   logic [7:0] col = 8'h00;
   logic       col_valid = 1'b0;
   logic       spi_din, spi_clk, spi_cs_n, busy, frame_done;
   logic [2:0] state_dbg;

   max7219_sequencer #(.CLK_DIV(CLK_DIV), .FRAME_GAP(FRAME_GAP)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .intensity(intensity),
      .row_req(row_req), .row_sel(row_sel), .col(col), .col_valid(col_valid),
      .spi_din(spi_din), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
      .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_fail = 0;
   logic [15:0] exp_q[$];

   logic [15:0] frame_w [8] = '{16'h01A0, 16'h02A1, 16'h03A2, 16'h04A3,
                                16'h05A4, 16'h06A5, 16'h07A6, 16'h08A7};
   logic [15:0] init5_w [5] = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A05, 16'h0F00};
   logic [15:0] init9_w [5] = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A09, 16'h0F00};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // sel: 0 spi_cs_n, 1 row_req, 2 frame_done, 3 busy, other: row 3 requested
   task automatic wait_for(input int sel, input logic val, input int budget, input string name);
      int n;
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         case (sel)
            0:       hit = (spi_cs_n == val);
            1:       hit = (row_req == val);
            2:       hit = (frame_done == val);
            3:       hit = (busy == val);
            default: hit = row_req && (row_sel == 3'd3);
         endcase
      end
      if (!hit) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout %s: got no event expected one within %0d cycles", name, budget);
      end
   endtask

   // Row source: answers row_req after 2 cycles (longer on the stall row)
   logic resp_en = 1'b1;
   logic spur_req = 1'b0;
   int   stall_row = 8;
   int   wait_cnt = 0;
   always @(negedge clk) begin
      if (col_valid) begin
         col_valid = 1'b0;
         wait_cnt  = 0;
      end else if (spur_req && !row_req) begin
         col_valid = 1'b1;
         col       = 8'h55;
         spur_req  = 1'b0;
      end else if (row_req && resp_en) begin
         if (wait_cnt >= ((int'(row_sel) == stall_row) ? 60 : 2)) begin
            col_valid = 1'b1;
            col       = 8'hA0 + {5'd0, row_sel};
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // Monitor: decode each CS-low window on spi_clk rising edges
   logic        in_word = 1'b0;
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   logic [15:0] mon_sh = 16'h0;
   int          mon_bits = 0;
   int          mon_low = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         in_word = 1'b0;
      end else begin
         if (in_word && spi_cs_n) begin
            in_word = 1'b0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL spi_word: got %04h expected none", mon_sh);
            end else begin
               check("spi_word", {16'h0, mon_sh}, {16'h0, exp_q.pop_front()});
            end
            check("word_bits", mon_bits, 16);
            check("word_low_cycles", mon_low, 32 * CLK_DIV);
         end else if (!in_word && !spi_cs_n && prev_cs) begin
            in_word  = 1'b1;
            mon_sh   = 16'h0;
            mon_bits = 0;
            mon_low  = 0;
         end
         if (in_word) begin
            mon_low++;
            if (spi_clk && !prev_sclk) begin
               mon_sh = {mon_sh[14:0], spi_din};
               mon_bits++;
            end
         end
      end
      prev_cs   = rst_n ? spi_cs_n : 1'b1;
      prev_sclk = spi_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      int t0, tf, bad;
      repeat (3) @(negedge clk);
      check("rst_cs_n", spi_cs_n, 1);
      check("rst_spi_clk", spi_clk, 0);
      check("rst_spi_din", spi_din, 0);
      check("rst_row_req", row_req, 0);
      check("rst_row_sel", row_sel, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_state", state_dbg, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Init sequence followed by frame 1
      foreach (init5_w[i]) exp_q.push_back(init5_w[i]);
      foreach (frame_w[i]) exp_q.push_back(frame_w[i]);
      enable = 1'b1;
      wait_for(0, 1'b0, 20, "init_start");
      t0 = cyc;
      wait_for(1, 1'b1, 400, "first_row_req");
      check("init_duration", cyc - t0, 165);
      check("first_row_sel", row_sel, 0);

      wait_for(2, 1'b1, 600, "frame1_done");
      tf = cyc;
      spur_req  = 1'b1;
      stall_row = 3;
      foreach (frame_w[i]) exp_q.push_back(frame_w[i]);
      exp_q.push_back(16'h0A09);
      foreach (frame_w[i]) exp_q.push_back(frame_w[i]);
      @(negedge clk);
      check("frame_done_pulse", frame_done, 0);
      wait_for(1, 1'b1, 40, "gap_row_req");
      check("gap_len", cyc - tf, 16);
      check("frame2_row_sel", row_sel, 0);

      // Stall on row 3 of frame 2
      wait_for(4, 1'b1, 600, "row3_req");
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (!row_req || row_sel != 3'd3 || !spi_cs_n || spi_clk) bad++;
         @(negedge clk);
      end
      check("stall_bad_cycles", bad, 0);
      check("stall_row_sel", row_sel, 3);
      stall_row = 8;
      intensity = 4'h9;

      wait_for(2, 1'b1, 1000, "frame2_done");
      @(negedge clk);
      wait_for(2, 1'b1, 1000, "frame3_done");
      exp_q.push_back(16'h01A0);

      // Disable 4 bits into a word: word and LATCH finish, then idle
      wait_for(0, 1'b0, 100, "frame4_word");
      t0 = cyc;
      repeat (8) @(negedge clk);
      enable = 1'b0;
      wait_for(3, 1'b0, 100, "busy_fall");
      check("disable_busy_fall", cyc - t0, 33);
      check("disable_cs_n", spi_cs_n, 1);

      // Reset mid-word: outputs return at once, aborted word is not sent
      repeat (3) @(negedge clk);
      resp_en = 1'b0;
      enable  = 1'b1;
      wait_for(0, 1'b0, 20, "rst_word_start");
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cs_n", spi_cs_n, 1);
      check("midrst_spi_clk", spi_clk, 0);
      check("midrst_spi_din", spi_din, 0);
      check("midrst_busy", busy, 0);
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      foreach (init9_w[i]) exp_q.push_back(init9_w[i]);
      enable = 1'b1;
      wait_for(1, 1'b1, 400, "reinit_row_req");
      check("reinit_row_sel", row_sel, 0);
      enable = 1'b0;
      @(negedge clk);
      check("abort_row_req", row_req, 0);
      check("abort_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
